// File: rtl/wash_cycle_sequencer_if.sv
// rtl/wash_cycle_sequencer_if.sv - panel/driver signal bundle for the wash cycle sequencer
interface wash_cycle_sequencer_if #(
    parameter int SEC_W = 16
);
    logic [1:0]       clk_freq;
    logic             coin_in;
    logic             double_wash;
    logic             timer_pause;
    logic             wash_done;
    logic             busy;
    logic [2:0]       phase;
    logic [SEC_W-1:0] secs_left;

    modport master (
        output clk_freq, coin_in, double_wash, timer_pause,
        input  wash_done, busy, phase, secs_left
    );

    modport slave (
        input  clk_freq, coin_in, double_wash, timer_pause,
        output wash_done, busy, phase, secs_left
    );
endinterface

// File: rtl/wash_cycle_sequencer.sv
// rtl/wash_cycle_sequencer.sv - fill/wash/rinse/spin sequencer with 1 s prescaler; option macro WCS_PAUSE_ANY_EN
module wash_cycle_sequencer #(
    parameter int BASE_HZ = 1_000_000,
    parameter int FILL_S  = 120,
    parameter int WASH_S  = 300,
    parameter int RINSE_S = 120,
    parameter int SPIN_S  = 60,
    parameter int DIV_W   = 32,
    parameter int SEC_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wash_cycle_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4
    } state_t;

    localparam int MAX_S = (FILL_S > WASH_S ? FILL_S : WASH_S) > (RINSE_S > SPIN_S ? RINSE_S : SPIN_S)
                         ? (FILL_S > WASH_S ? FILL_S : WASH_S) : (RINSE_S > SPIN_S ? RINSE_S : SPIN_S);

    if (FILL_S < 1 || WASH_S < 1 || RINSE_S < 1 || SPIN_S < 1) begin : g_bad_duration
        $error("wash_cycle_sequencer: every phase duration must be at least 1 second");
    end
    if (DIV_W < 63 && ((64'(BASE_HZ) << 3) - 64'd1) >= (64'd1 << DIV_W)) begin : g_bad_div_w
        $error("wash_cycle_sequencer: DIV_W cannot hold the largest prescaler value");
    end
    if (SEC_W < 31 && MAX_S >= (1 << SEC_W)) begin : g_bad_sec_w
        $error("wash_cycle_sequencer: SEC_W cannot hold the longest phase duration");
    end

    localparam logic [DIV_W-1:0] BASE_DIV  = DIV_W'(BASE_HZ);
    localparam logic [SEC_W-1:0] FILL_DUR  = SEC_W'(FILL_S);
    localparam logic [SEC_W-1:0] WASH_DUR  = SEC_W'(WASH_S);
    localparam logic [SEC_W-1:0] RINSE_DUR = SEC_W'(RINSE_S);
    localparam logic [SEC_W-1:0] SPIN_DUR  = SEC_W'(SPIN_S);
    localparam logic [SEC_W-1:0] ONE_SEC   = SEC_W'(1);

    state_t           state_q, state_d, next_phase;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [SEC_W-1:0] secs_q, secs_d;
    logic             pass_q, pass_d;
    logic [1:0]       cfg_freq_q, cfg_freq_d;
    logic             cfg_double_q, cfg_double_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] div_last;
    logic             pause_hold;

    function automatic logic [SEC_W-1:0] dur_of(input state_t s);
        case (s)
            S_FILL:  dur_of = FILL_DUR;
            S_WASH:  dur_of = WASH_DUR;
            S_RINSE: dur_of = RINSE_DUR;
            S_SPIN:  dur_of = SPIN_DUR;
            default: dur_of = '0;
        endcase
    endfunction

    // Divisor comes from the frequency select latched at coin time, never the live input
    assign div_last = (BASE_DIV << cfg_freq_q) - DIV_W'(1);

`ifdef WCS_PAUSE_ANY_EN
    assign pause_hold = bus.timer_pause && (state_q != S_IDLE);
`else
    assign pause_hold = bus.timer_pause && (state_q == S_SPIN);
`endif

    // State and timer registers; reset returns to an idle, unconfigured machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            secs_q       <= '0;
            pass_q       <= 1'b0;
            cfg_freq_q   <= 2'b00;
            cfg_double_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            secs_q       <= secs_d;
            pass_q       <= pass_d;
            cfg_freq_q   <= cfg_freq_d;
            cfg_double_q <= cfg_double_d;
            done_q       <= done_d;
        end
    end

    // Phase sequencing: start on coin, count seconds, advance when the last second expires
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        secs_d       = secs_q;
        pass_d       = pass_q;
        cfg_freq_d   = cfg_freq_q;
        cfg_double_d = cfg_double_q;
        done_d       = done_q;
        next_phase   = S_IDLE;

        case (state_q)
            S_IDLE: begin
                if (bus.coin_in) begin
                    state_d      = S_FILL;
                    cfg_freq_d   = bus.clk_freq;
                    cfg_double_d = bus.double_wash;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    presc_d      = '0;
                    secs_d       = FILL_DUR;
                end
            end
            S_FILL, S_WASH, S_RINSE, S_SPIN: begin
                if (!pause_hold) begin
                    if (presc_q == div_last) begin
                        presc_d = '0;
                        if (secs_q == ONE_SEC) begin
                            case (state_q)
                                S_FILL:  next_phase = S_WASH;
                                S_WASH:  next_phase = S_RINSE;
                                S_RINSE: begin
                                    if (cfg_double_q && !pass_q) begin
                                        next_phase = S_WASH;
                                        pass_d     = 1'b1;
                                    end else begin
                                        next_phase = S_SPIN;
                                    end
                                end
                                default: begin
                                    next_phase = S_IDLE;
                                    done_d     = 1'b1;
                                    pass_d     = 1'b0;
                                end
                            endcase
                            state_d = next_phase;
                            secs_d  = dur_of(next_phase);
                        end else begin
                            secs_d = secs_q - ONE_SEC;
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                presc_d = '0;
                secs_d  = '0;
                pass_d  = 1'b0;
            end
        endcase
    end

    assign bus.phase     = state_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.secs_left = secs_q;
    assign bus.wash_done = done_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// tb/tb_wash_cycle_sequencer.sv - randomized and directed bench against a cycle-count reference model
module tb_wash_cycle_sequencer;

    localparam int BASE_HZ = 4;
    localparam int FILL_S  = 2;
    localparam int WASH_S  = 3;
    localparam int RINSE_S = 2;
    localparam int SPIN_S  = 1;
    localparam int SEC_W   = 16;
`ifdef WCS_PAUSE_ANY_EN
    localparam bit PAUSE_ANY = 1'b1;
`else
    localparam bit PAUSE_ANY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // model state: phase plan as a queue of phase numbers, cycles remaining in current phase
    int   m_phase = 0;
    int   m_rem = 0;
    int   m_div = BASE_HZ;
    int   m_done = 0;
    int   m_plan[$];

    wash_cycle_sequencer_if #(.SEC_W(SEC_W)) bus ();

    wash_cycle_sequencer #(
        .BASE_HZ(BASE_HZ), .FILL_S(FILL_S), .WASH_S(WASH_S),
        .RINSE_S(RINSE_S), .SPIN_S(SPIN_S), .DIV_W(32), .SEC_W(SEC_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dur_s(input int p);
        case (p)
            1: return FILL_S;
            2: return WASH_S;
            3: return RINSE_S;
            4: return SPIN_S;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_rem   = 0;
        m_done  = 0;
        m_plan.delete();
    endtask

    // one clock edge of the reference: plan-driven, counting whole phase lengths in cycles
    task automatic model_edge(input bit coin, input bit dbl, input bit pause, input int freq);
        if (m_phase == 0) begin
            if (coin) begin
                m_div  = BASE_HZ << freq;
                m_done = 0;
                if (dbl) m_plan = '{1, 2, 3, 2, 3, 4};
                else     m_plan = '{1, 2, 3, 4};
                m_phase = m_plan.pop_front();
                m_rem   = dur_s(m_phase) * m_div;
            end
        end else if (!(pause && (PAUSE_ANY || m_phase == 4))) begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_plan.size() == 0) begin
                    m_phase = 0;
                    m_done  = 1;
                end else begin
                    m_phase = m_plan.pop_front();
                    m_rem   = dur_s(m_phase) * m_div;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("phase", bus.phase, m_phase);
        check("busy", bus.busy, (m_phase != 0));
        check("secs_left", bus.secs_left, (m_phase == 0) ? 0 : (m_rem + m_div - 1) / m_div);
        check("wash_done", bus.wash_done, m_done);
    endtask

    // drive inputs at the falling edge, step model on rising edge, compare at next falling edge
    task automatic step(input bit coin, input bit dbl, input bit pause, input int freq);
        bus.coin_in     = coin;
        bus.double_wash = dbl;
        bus.timer_pause = pause;
        bus.clk_freq    = 2'(freq);
        @(posedge clk);
        model_edge(coin, dbl, pause, freq);
        @(negedge clk);
        compare_all();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_phase", bus.phase, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_secs", bus.secs_left, 0);
        check("rst_done", bus.wash_done, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    // full cycle from IDLE; pause window of plen cycles starts two cycles into phase pp
    task automatic directed(input string tag, input bit dbl, input int f0, input int f1,
                            input int pp, input int plen, input int exp_cycles);
        int  k;
        int  pcnt;
        bit  pz;
        step(1'b1, dbl, 1'b0, f0);
        k = 0;
        pcnt = plen;
        while (!bus.wash_done && k < 2000) begin
            pz = 1'b0;
            if (m_phase == pp && pcnt > 0 && m_rem <= dur_s(pp) * m_div - 2) begin
                pz = 1'b1;
                pcnt--;
            end
            step((k % 7) == 3, ~dbl, pz, f1);
            k++;
        end
        check(tag, k, exp_cycles);
    endtask

    initial begin
        bus.coin_in     = 1'b0;
        bus.double_wash = 1'b0;
        bus.timer_pause = 1'b0;
        bus.clk_freq    = 2'b00;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 0);

        directed("single_done_t", 1'b0, 0, 0, 7, 0, 32);
        directed("double_done_t", 1'b1, 0, 0, 7, 0, 52);
        directed("spin_pause_done_t", 1'b0, 0, 0, 4, 5, 37);
        directed("wash_pause_done_t", 1'b0, 0, 0, 2, 6, PAUSE_ANY ? 38 : 32);
        directed("freq3_done_t", 1'b0, 3, 0, 7, 0, 256);

        step(1'b1, 1'b0, 1'b0, 0);
        repeat (12) step(1'b0, 1'b0, 1'b0, 0);
        check("in_wash", bus.phase, 2);
        reset_pulse();
        directed("after_reset_done_t", 1'b0, 0, 0, 7, 0, 32);

        for (int i = 0; i < 5000; i++) begin
            bit coin;
            bit dbl;
            bit pz;
            int fq;
            if (i % 1700 == 850) reset_pulse();
            coin = ($urandom_range(0, 3) == 0);
            dbl  = $urandom_range(0, 1);
            pz   = ($urandom_range(0, 9) == 0);
            fq   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            step(coin, dbl, pz, fq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
